memory_port_arbiter: RTL and testbench

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one single-port SRAM between a fetch requester (0) and a data
//   requester (1). One SRAM access is issued per accepted request. Read data
//   comes back from the SRAM one cycle later and is steered to the owner.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : contention goes to the requester not
//                                   granted most recently.
//                       undefined : requester 1 (data) always wins contention.
//
// Handshake: a request is accepted in a cycle where reqN_valid and reqN_ready
//   are both high. The requester holds valid and payload stable until that
//   cycle. rspN_valid pulses for one cycle per accepted read and has no
//   back-pressure.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            request handshake (N = 0 fetch, 1 data)
//   reqN_address/write_enable/write_data  request payload
//   rspN_valid, rspN_read_data  read response; data holds when valid is low
//   sram_enable, sram_write_enable, sram_address, sram_write_data  SRAM drive
//   sram_read_data              SRAM read data, one cycle after a read
//   stall_count0/1              saturating count of valid-but-not-granted cycles
module memory_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic                  req0_write_enable,
    input  logic [DATA_WIDTH-1:0] req0_write_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic                  req1_write_enable,
    input  logic [DATA_WIDTH-1:0] req1_write_data,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_read_data,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_read_data,
    output logic                  sram_enable,
    output logic                  sram_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic [CNT_WIDTH-1:0]  stall_count0,
    output logic [CNT_WIDTH-1:0]  stall_count1
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  grant0, grant1;
    logic                  pending_q, pending_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic [CNT_WIDTH-1:0]  stall0_q, stall0_d;
    logic [CNT_WIDTH-1:0]  stall1_q, stall1_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_grant_q, last_grant_d;
`endif

    // Grant selection; nothing is granted while reset is high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_grant_q) grant0 = 1'b1;
                else              grant1 = 1'b1;
`else
                grant1 = 1'b1;
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // SRAM drive comes straight from the granted payload in the accepting cycle.
    always_comb begin
        sram_enable       = 1'b0;
        sram_write_enable = 1'b0;
        sram_address      = '0;
        sram_write_data   = '0;
        if (grant1) begin
            sram_enable       = 1'b1;
            sram_write_enable = req1_write_enable;
            sram_address      = req1_address;
            sram_write_data   = req1_write_data;
        end else if (grant0) begin
            sram_enable       = 1'b1;
            sram_write_enable = req0_write_enable;
            sram_address      = req0_address;
            sram_write_data   = req0_write_data;
        end
    end

    // Responses are masked while reset is high so a read accepted just before
    // reset is dropped rather than delivered.
    assign rsp0_valid     = !rst && pending_q && !owner_q;
    assign rsp1_valid     = !rst && pending_q &&  owner_q;
    assign rsp0_read_data = rst ? '0 : (rsp0_valid ? sram_read_data : rsp0_data_q);
    assign rsp1_read_data = rst ? '0 : (rsp1_valid ? sram_read_data : rsp1_data_q);

    assign stall_count0 = stall0_q;
    assign stall_count1 = stall1_q;

    always_comb begin
        pending_d   = sram_enable && !sram_write_enable;
        owner_d     = pending_d ? grant1 : owner_q;
        rsp0_data_d = rsp0_valid ? sram_read_data : rsp0_data_q;
        rsp1_data_d = rsp1_valid ? sram_read_data : rsp1_data_q;
        stall0_d    = stall0_q;
        stall1_d    = stall1_q;
        if (req0_valid && !grant0 && (stall0_q != '1)) stall0_d = stall0_q + CNT_ONE;
        if (req1_valid && !grant1 && (stall1_q != '1)) stall1_d = stall1_q + CNT_ONE;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
        if (grant1)      last_grant_d = 1'b1;
        else if (grant0) last_grant_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= 1'b0;
            owner_q      <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            stall0_q     <= '0;
            stall1_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            pending_q    <= pending_d;
            owner_q      <= owner_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            stall0_q     <= stall0_d;
            stall1_q     <= stall1_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req0_write_enable;
  logic [AW-1:0] req0_address;
  logic [DW-1:0] req0_write_data;
  logic          req1_valid, req1_ready, req1_write_enable;
  logic [AW-1:0] req1_address;
  logic [DW-1:0] req1_write_data;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_read_data, rsp1_read_data;
  logic          sram_enable, sram_write_enable;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data, sram_read_data;
  logic [CW-1:0] stall_count0, stall_count1;

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_address(req0_address),
    .req0_write_enable(req0_write_enable), .req0_write_data(req0_write_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_address(req1_address),
    .req1_write_enable(req1_write_enable), .req1_write_data(req1_write_data),
    .rsp0_valid(rsp0_valid), .rsp0_read_data(rsp0_read_data),
    .rsp1_valid(rsp1_valid), .rsp1_read_data(rsp1_read_data),
    .sram_enable(sram_enable), .sram_write_enable(sram_write_enable),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data),
    .stall_count0(stall_count0), .stall_count1(stall_count1)
  );

  // ---------------- SRAM model (registered read) ----------------
  logic [DW-1:0] init_mem [0:255];
  logic [DW-1:0] sram_mem [0:255];
  logic          mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_mem[i];
    end else if (sram_enable) begin
      if (sram_write_enable) sram_mem[sram_address[7:0]] <= sram_write_data;
      else                   sram_read_data <= sram_mem[sram_address[7:0]];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_q[$];
  logic          own_q[$];
  logic [DW-1:0] mdl_rsp0, mdl_rsp1;
  logic [CW-1:0] mdl_stall0, mdl_stall1;
  logic          mdl_last;
  logic          last_g0, last_g1;
  int            n_cmp;
  int            n_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then advance past the
  // rising edge and drop any request that was accepted.
  task automatic cyc();
    logic          eg0, eg1, eo, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      own_q.delete();
      mdl_rsp0 = '0;
      mdl_rsp1 = '0;
      chk("rsp0_valid_rst", rsp0_valid, 1'b0);
      chk("rsp1_valid_rst", rsp1_valid, 1'b0);
    end else if (own_q.size() > 0) begin
      eo = own_q.pop_front();
      ed = exp_q.pop_front();
      chk("rsp0_valid", rsp0_valid, !eo);
      chk("rsp1_valid", rsp1_valid, eo);
      if (eo) mdl_rsp1 = ed;
      else    mdl_rsp0 = ed;
    end else begin
      chk("rsp0_valid_idle", rsp0_valid, 1'b0);
      chk("rsp1_valid_idle", rsp1_valid, 1'b0);
    end
    chk("rsp0_read_data", rsp0_read_data, mdl_rsp0);
    chk("rsp1_read_data", rsp1_read_data, mdl_rsp1);

`ifdef ARB_ROUND_ROBIN_EN
    eg0 = !rst && req0_valid && (!req1_valid || mdl_last);
`else
    eg0 = !rst && req0_valid && !req1_valid;
`endif
    eg1 = !rst && req1_valid && !eg0;
    chk("req0_ready", req0_ready, eg0);
    chk("req1_ready", req1_ready, eg1);
    chk("sram_enable", sram_enable, eg0 | eg1);
    if (eg0 || eg1) begin
      ea  = eg1 ? req1_address      : req0_address;
      ewe = eg1 ? req1_write_enable : req0_write_enable;
      ed  = eg1 ? req1_write_data   : req0_write_data;
      chk("sram_address", sram_address, ea);
      chk("sram_write_enable", sram_write_enable, ewe);
      if (ewe) begin
        chk("sram_write_data", sram_write_data, ed);
        ref_mem[ea[7:0]] = ed;
      end else begin
        exp_q.push_back(ref_mem[ea[7:0]]);
        own_q.push_back(eg1);
      end
      mdl_last = eg1;
    end

    chk("stall_count0", stall_count0, mdl_stall0);
    chk("stall_count1", stall_count1, mdl_stall1);
    if (rst) begin
      mdl_stall0 = '0;
      mdl_stall1 = '0;
      mdl_last   = 1'b1;
    end else begin
      if (req0_valid && !eg0 && mdl_stall0 != 4'hF) mdl_stall0 = mdl_stall0 + 4'd1;
      if (req1_valid && !eg1 && mdl_stall1 != 4'hF) mdl_stall1 = mdl_stall1 + 4'd1;
    end
    last_g0 = req0_ready;
    last_g1 = req1_ready;
    @(posedge clk);
    #1;
    if (last_g0) req0_valid = 1'b0;
    if (last_g1) req1_valid = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic we, input logic [7:0] a, input logic [DW-1:0] d);
    req0_valid = 1'b1; req0_write_enable = we; req0_address = {24'h0, a}; req0_write_data = d;
  endtask

  task automatic drive1(input logic we, input logic [7:0] a, input logic [DW-1:0] d);
    req1_valid = 1'b1; req1_write_enable = we; req1_address = {24'h0, a}; req1_write_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] gseq;
  logic [3:0] gexp;

  initial begin
    n_cmp = 0; n_mis = 0;
    mdl_rsp0 = '0; mdl_rsp1 = '0; mdl_stall0 = '0; mdl_stall1 = '0; mdl_last = 1'b1;
    req0_valid = 0; req0_write_enable = 0; req0_address = '0; req0_write_data = '0;
    req1_valid = 0; req1_write_enable = 0; req1_address = '0; req1_write_data = '0;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10]  = 32'hDEADBEEF;
    mem_init = 1'b1;
    rst = 1'b1;
    cyc();
    mem_init = 1'b0;
    do_reset();

    // Single read: ready in cycle t, one-cycle response in t+1.
    drive0(1'b0, 8'h10, '0);
    cyc();
    cyc();
    cyc();
    chk("rsp0_hold_deadbeef", rsp0_read_data, 32'hDEADBEEF);

    // Write by data port, then read-back by fetch port in the next cycle.
    drive1(1'b1, 8'h20, 32'h55);
    cyc();
    drive0(1'b0, 8'h20, '0);
    cyc();
    cyc();
    chk("rsp0_readback_55", rsp0_read_data, 32'h55);

    // Back-to-back alternating reads.
    drive0(1'b0, 8'h01, '0); cyc();
    drive1(1'b0, 8'h02, '0); cyc();
    drive0(1'b0, 8'h03, '0); cyc();
    cyc();
    chk("rsp1_alt_data", rsp1_read_data, ref_mem[8'h02]);
    chk("rsp0_alt_data", rsp0_read_data, ref_mem[8'h03]);

    // Reset in the cycle after a read is accepted drops the response.
    drive0(1'b0, 8'h04, '0); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; cyc();
    cyc();
    chk("stall0_after_rst", stall_count0, 4'd0);
    chk("stall1_after_rst", stall_count1, 4'd0);

    // Contention for four cycles starting from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!req0_valid) drive0(1'b0, 8'(8'h30 + i), '0);
      if (!req1_valid) drive1(1'b0, 8'(8'h40 + i), '0);
      cyc();
      gseq[3-i] = last_g1;
    end
`ifdef ARB_ROUND_ROBIN_EN
    gexp = 4'b0101;
`else
    gexp = 4'b1111;
    chk("stall0_contention", stall_count0, 4'd4);
`endif
    chk("grant_sequence", gseq, gexp);
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

`ifndef ARB_ROUND_ROBIN_EN
    // Starvation under fixed priority saturates the counter.
    do_reset();
    drive0(1'b0, 8'h50, '0);
    for (int i = 0; i < 20; i++) begin
      if (!req1_valid) drive1(1'b0, 8'(8'h60 + i), '0);
      cyc();
    end
    chk("stall0_saturated", stall_count0, 4'hF);
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
`endif

    // Random mixed traffic with sticky requests.
    for (int i = 0; i < 60; i++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1)
        drive0(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom);
      if (!req1_valid && $urandom_range(0, 1) == 1)
        drive1(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom);
      cyc();
    end
    for (int i = 0; i < 6; i++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
